// File: rtl/cpu_axi_master_if.sv
// Core-side command/data/response streams plus the AXI3 master channels of cpu_axi_master.
// master: the engine's own view; slave: the core and AXI fabric around it.
interface cpu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic [ID_W-1:0]   cmd_id;

  logic              wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [STRB_W-1:0] wd_strb;

  logic              rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic [ID_W-1:0]   rd_id;
  logic [1:0]        rd_resp;

  logic              bresp_valid;
  logic [ID_W-1:0]   bresp_id;
  logic [1:0]        bresp;
  logic              err_4k;

  logic [ID_W-1:0]   axi_awid, axi_arid, axi_bid, axi_rid;
  logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
  logic [3:0]        axi_awlen, axi_arlen, axi_awcache, axi_arcache;
  logic [2:0]        axi_awsize, axi_arsize, axi_awprot, axi_arprot;
  logic [1:0]        axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic              axi_awlock, axi_arlock;
  logic              axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [DATA_W-1:0] axi_wdata, axi_rdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_wlast, axi_wvalid, axi_wready;
  logic              axi_bvalid, axi_bready;
  logic              axi_rlast, axi_rvalid, axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, output cmd_ready,
    input  wd_valid, wd_data, wd_strb, output wd_ready,
    output rd_valid, rd_data, rd_id, rd_resp, rd_last, input rd_ready,
    output bresp_valid, bresp_id, bresp, err_4k,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
    output axi_awcache, axi_awprot, axi_awvalid, input axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, input axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid, output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
    output axi_arcache, axi_arprot, axi_arvalid, input axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, output axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, input cmd_ready,
    output wd_valid, wd_data, wd_strb, input wd_ready,
    input  rd_valid, rd_data, rd_id, rd_resp, rd_last, output rd_ready,
    input  bresp_valid, bresp_id, bresp, err_4k,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
    input  axi_awcache, axi_awprot, axi_awvalid, output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid, input axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
    input  axi_arcache, axi_arprot, axi_arvalid, output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, input axi_rready
  );
endinterface

// File: rtl/cpu_axi_master.sv
// AXI3 INCR burst master: core cmd/wd stream -> AW/W/AR; `CPU_AXI_MASTER_4K_CHECK_EN rejects 4 KB-crossing bursts.
// Latency: AW/AR valid the cycle after command accept; W, R and B are combinational pass-through.
// Backpressure: cmd_ready low while AW/AR register busy, a W burst is open or MAX_OUTSTD reached; wd/rd follow AXI ready.
module cpu_axi_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 8,
  parameter int MAX_OUTSTD = 4
) (
  input logic             acr_clk,
  input logic             acr_rst,
  cpu_axi_master_if.master bus
);
  localparam logic [2:0] AXSIZE   = 3'($clog2(DATA_W / 8));
  localparam logic [4:0] OS_LIMIT = 5'(MAX_OUTSTD);

  typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} wstate_e;

  wstate_e           wstate_q, wstate_d;
  logic [3:0]        beat_q, beat_d, wlen_q, wlen_d;
  logic              discard_q, discard_d;
  logic              aw_vld_q, aw_vld_d, ar_vld_q, ar_vld_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [3:0]        aw_len_q, aw_len_d, ar_len_q, ar_len_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [3:0]        wr_os_q, wr_os_d, rd_os_q, rd_os_d;
  logic              err_4k_q, err_4k_d;

  logic cross_4k, wr_rdy, rd_rdy, cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_last_hs, w_active;

`ifdef CPU_AXI_MASTER_4K_CHECK_EN
  localparam int STRB_W = DATA_W / 8;
  logic [13:0] burst_end;
  assign burst_end = {2'b00, bus.cmd_addr[11:0]} + (14'(bus.cmd_len) + 14'd1) * 14'(STRB_W);
  assign cross_4k  = burst_end > 14'd4096;
`else
  assign cross_4k  = 1'b0;
`endif

  // A register being drained this cycle already counts as outstanding, so the limit is never overshot.
  assign wr_rdy = (!aw_vld_q || bus.axi_awready) && (wstate_q == W_IDLE) &&
                  (({1'b0, wr_os_q} + {4'd0, aw_vld_q}) < OS_LIMIT);
  assign rd_rdy = (!ar_vld_q || bus.axi_arready) &&
                  (({1'b0, rd_os_q} + {4'd0, ar_vld_q}) < OS_LIMIT);

  assign bus.cmd_ready = bus.cmd_write ? wr_rdy : rd_rdy;
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
  assign aw_hs         = aw_vld_q && bus.axi_awready;
  assign ar_hs         = ar_vld_q && bus.axi_arready;
  assign b_hs          = bus.axi_bvalid;
  assign r_last_hs     = bus.axi_rvalid && bus.rd_ready && bus.axi_rlast;
  assign w_active      = (wstate_q == W_DATA);
  assign w_hs          = bus.wd_valid && bus.wd_ready;

  assign bus.axi_awvalid = aw_vld_q;
  assign bus.axi_awaddr  = aw_addr_q;
  assign bus.axi_awlen   = aw_len_q;
  assign bus.axi_awid    = aw_id_q;
  assign bus.axi_awsize  = AXSIZE;
  assign bus.axi_awburst = 2'b01;
  assign bus.axi_awlock  = 1'b0;
  assign bus.axi_awcache = 4'b0011;
  assign bus.axi_awprot  = 3'b000;

  assign bus.axi_arvalid = ar_vld_q;
  assign bus.axi_araddr  = ar_addr_q;
  assign bus.axi_arlen   = ar_len_q;
  assign bus.axi_arid    = ar_id_q;
  assign bus.axi_arsize  = AXSIZE;
  assign bus.axi_arburst = 2'b01;
  assign bus.axi_arlock  = 1'b0;
  assign bus.axi_arcache = 4'b0011;
  assign bus.axi_arprot  = 3'b000;

  // Discarded bursts still drain the core's wd stream but never reach the W channel.
  assign bus.axi_wvalid = w_active && !discard_q && bus.wd_valid;
  assign bus.wd_ready   = w_active && (discard_q || bus.axi_wready);
  assign bus.axi_wdata  = bus.wd_data;
  assign bus.axi_wstrb  = bus.wd_strb;
  assign bus.axi_wlast  = w_active && (beat_q == wlen_q);

  assign bus.axi_bready  = 1'b1;
  assign bus.bresp_valid = bus.axi_bvalid;
  assign bus.bresp_id    = bus.axi_bid;
  assign bus.bresp       = bus.axi_bresp;

  assign bus.rd_valid   = bus.axi_rvalid;
  assign bus.rd_data    = bus.axi_rdata;
  assign bus.rd_id      = bus.axi_rid;
  assign bus.rd_resp    = bus.axi_rresp;
  assign bus.rd_last    = bus.axi_rlast;
  assign bus.axi_rready = bus.rd_ready;

  assign bus.err_4k = err_4k_q;

  always_comb begin
    wstate_d  = wstate_q;
    beat_d    = beat_q;
    wlen_d    = wlen_q;
    discard_d = discard_q;
    aw_vld_d  = aw_vld_q && !aw_hs;
    aw_addr_d = aw_addr_q;
    aw_len_d  = aw_len_q;
    aw_id_d   = aw_id_q;
    ar_vld_d  = ar_vld_q && !ar_hs;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    ar_id_d   = ar_id_q;
    wr_os_d   = wr_os_q;
    rd_os_d   = rd_os_q;
    err_4k_d  = cmd_hs && cross_4k;

    if (cmd_hs && bus.cmd_write) begin
      wstate_d  = W_DATA;
      beat_d    = 4'd0;
      wlen_d    = bus.cmd_len;
      discard_d = cross_4k;
      if (!cross_4k) begin
        aw_vld_d  = 1'b1;
        aw_addr_d = bus.cmd_addr;
        aw_len_d  = bus.cmd_len;
        aw_id_d   = bus.cmd_id;
      end
    end else if (w_active && w_hs) begin
      if (beat_q == wlen_q) wstate_d = W_IDLE;
      else                  beat_d   = beat_q + 4'd1;
    end

    if (cmd_hs && !bus.cmd_write && !cross_4k) begin
      ar_vld_d  = 1'b1;
      ar_addr_d = bus.cmd_addr;
      ar_len_d  = bus.cmd_len;
      ar_id_d   = bus.cmd_id;
    end

    // Responses for transactions lost across a reset must not wrap the counters.
    case ({aw_hs, b_hs})
      2'b10:   wr_os_d = wr_os_q + 4'd1;
      2'b01:   wr_os_d = (wr_os_q == 4'd0) ? 4'd0 : wr_os_q - 4'd1;
      default: wr_os_d = wr_os_q;
    endcase
    case ({ar_hs, r_last_hs})
      2'b10:   rd_os_d = rd_os_q + 4'd1;
      2'b01:   rd_os_d = (rd_os_q == 4'd0) ? 4'd0 : rd_os_q - 4'd1;
      default: rd_os_d = rd_os_q;
    endcase
  end

  always_ff @(posedge acr_clk) begin
    if (acr_rst) begin
      wstate_q  <= W_IDLE;
      beat_q    <= '0;
      wlen_q    <= '0;
      discard_q <= 1'b0;
      aw_vld_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_id_q   <= '0;
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
      wr_os_q   <= '0;
      rd_os_q   <= '0;
      err_4k_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      beat_q    <= beat_d;
      wlen_q    <= wlen_d;
      discard_q <= discard_d;
      aw_vld_q  <= aw_vld_d;
      aw_addr_q <= aw_addr_d;
      aw_len_q  <= aw_len_d;
      aw_id_q   <= aw_id_d;
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_id_q   <= ar_id_d;
      wr_os_q   <= wr_os_d;
      rd_os_q   <= rd_os_d;
      err_4k_q  <= err_4k_d;
    end
  end
endmodule

// File: tb/tb_cpu_axi_master.sv
// Scoreboard bench for cpu_axi_master: directed commands push expected AXI/response traffic, monitors pop and compare.
`timescale 1ns/1ps
module tb_cpu_axi_master;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 8, MAX_OUTSTD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_axi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  cpu_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTSTD(MAX_OUTSTD))
    dut (.acr_clk(clk), .acr_rst(rst), .bus(bus));

  typedef struct packed {logic [31:0] addr; logic [3:0] len; logic [7:0] id;} ax_t;
  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last;} w_t;
  typedef struct packed {logic [7:0] id; logic [1:0] resp;} b_t;
  typedef struct packed {logic [63:0] data; logic [7:0] id; logic [1:0] resp; logic last;} r_t;

  ax_t exp_aw[$], exp_ar[$];
  w_t  exp_w[$];
  b_t  exp_b[$];
  r_t  exp_r[$];
  int  n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitors ----------------
  ax_t m_ax; w_t m_w; b_t m_b; r_t m_r;
  always @(negedge clk) if (!rst) begin
    if (bus.axi_awvalid && bus.axi_awready) begin
      check("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
      if (exp_aw.size() != 0) begin
        m_ax = exp_aw.pop_front();
        check("awaddr", 64'(bus.axi_awaddr), 64'(m_ax.addr));
        check("awlen", 64'(bus.axi_awlen), 64'(m_ax.len));
        check("awid", 64'(bus.axi_awid), 64'(m_ax.id));
        check("awsize", 64'(bus.axi_awsize), 64'd3);
        check("awburst", 64'(bus.axi_awburst), 64'd1);
        check("awcache", 64'(bus.axi_awcache), 64'd3);
      end
    end
    if (bus.axi_arvalid && bus.axi_arready) begin
      check("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
      if (exp_ar.size() != 0) begin
        m_ax = exp_ar.pop_front();
        check("araddr", 64'(bus.axi_araddr), 64'(m_ax.addr));
        check("arlen", 64'(bus.axi_arlen), 64'(m_ax.len));
        check("arid", 64'(bus.axi_arid), 64'(m_ax.id));
        check("arsize", 64'(bus.axi_arsize), 64'd3);
      end
    end
    if (bus.axi_wvalid && bus.axi_wready) begin
      check("w_expected", 64'(exp_w.size() != 0), 64'd1);
      if (exp_w.size() != 0) begin
        m_w = exp_w.pop_front();
        check("wdata", bus.axi_wdata, m_w.data);
        check("wstrb", 64'(bus.axi_wstrb), 64'(m_w.strb));
        check("wlast", 64'(bus.axi_wlast), 64'(m_w.last));
      end
    end
    if (bus.bresp_valid) begin
      check("b_expected", 64'(exp_b.size() != 0), 64'd1);
      check("bready", 64'(bus.axi_bready), 64'd1);
      if (exp_b.size() != 0) begin
        m_b = exp_b.pop_front();
        check("bresp_id", 64'(bus.bresp_id), 64'(m_b.id));
        check("bresp", 64'(bus.bresp), 64'(m_b.resp));
      end
    end
    if (bus.rd_valid && bus.rd_ready) begin
      check("r_expected", 64'(exp_r.size() != 0), 64'd1);
      if (exp_r.size() != 0) begin
        m_r = exp_r.pop_front();
        check("rd_data", bus.rd_data, m_r.data);
        check("rd_id", 64'(bus.rd_id), 64'(m_r.id));
        check("rd_resp", 64'(bus.rd_resp), 64'(m_r.resp));
        check("rd_last", 64'(bus.rd_last), 64'(m_r.last));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [7:0] id);
    bit done;
    done = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_len = len; bus.cmd_id = id;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1;
      tick();
    end
    if (!done) check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic burst(input int n, input int last_idx, input logic [63:0] base,
                       input logic [7:0] strb, input logic expect_w, input logic exp_err,
                       input logic exp_awv);
    for (int i = 0; i < n; i++) begin
      bit done;
      done = 0;
      bus.wd_valid = 1'b1; bus.wd_data = base + 64'(i); bus.wd_strb = strb;
      if (expect_w) exp_w.push_back('{data: base + 64'(i), strb: strb, last: (i == last_idx)});
      for (int t = 0; t < 50 && !done; t++) begin
        @(negedge clk);
        if (t == 0 && i == 0) begin
          check("err_4k_first", 64'(bus.err_4k), 64'(exp_err));
          check("awvalid_first", 64'(bus.axi_awvalid), 64'(exp_awv));
        end
        if (t == 0 && i == 1) check("err_4k_pulse_end", 64'(bus.err_4k), 64'd0);
        if (!expect_w) begin
          check("discard_wvalid", 64'(bus.axi_wvalid), 64'd0);
          check("discard_wd_ready", 64'(bus.wd_ready), 64'd1);
        end
        if (bus.wd_ready) done = 1;
        tick();
      end
      if (!done) check("wd_accept", 64'(bus.wd_ready), 64'd1);
    end
    bus.wd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] resp);
    bus.axi_bvalid = 1'b1; bus.axi_bid = id; bus.axi_bresp = resp;
    exp_b.push_back('{id: id, resp: resp});
    tick();
    bus.axi_bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [63:0] data, input logic [7:0] id, input logic [1:0] resp);
    bus.axi_rvalid = 1'b1; bus.axi_rdata = data; bus.axi_rid = id;
    bus.axi_rresp = resp; bus.axi_rlast = 1'b1;
    exp_r.push_back('{data: data, id: id, resp: resp, last: 1'b1});
    tick();
    bus.axi_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 1; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
    bus.wd_valid = 0; bus.wd_data = '0; bus.wd_strb = '0; bus.rd_ready = 1;
    bus.axi_awready = 1; bus.axi_wready = 1; bus.axi_arready = 1;
    bus.axi_bvalid = 0; bus.axi_bid = '0; bus.axi_bresp = '0;
    bus.axi_rvalid = 0; bus.axi_rid = '0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_awvalid", 64'(bus.axi_awvalid), 64'd0);
    check("rst_arvalid", 64'(bus.axi_arvalid), 64'd0);
    check("rst_wd_ready", 64'(bus.wd_ready), 64'd0);
    check("rst_err_4k", 64'(bus.err_4k), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_wr_os", 64'(dut.wr_os_q), 64'd0);
    tick();

    // single write burst, everything ready
    exp_aw.push_back('{addr: 32'h1000, len: 4'd3, id: 8'h5A});
    send_cmd(1, 32'h1000, 4'd3, 8'h5A);
    burst(4, 3, 64'hA000_0000_0000_0000, 8'hFF, 1, 0, 1);
    @(negedge clk) check("t1_wr_os_1", 64'(dut.wr_os_q), 64'd1);
    tick();
    send_b(8'h5A, 2'b00);
    @(negedge clk) check("t1_wr_os_0", 64'(dut.wr_os_q), 64'd0);
    tick();

    // four reads fill the outstanding limit
    for (int i = 0; i < 4; i++) begin
      exp_ar.push_back('{addr: 32'h2000 + 32'(i * 64), len: 4'd0, id: 8'h10 + 8'(i)});
      send_cmd(0, 32'h2000 + 32'(i * 64), 4'd0, 8'h10 + 8'(i));
    end
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h2100; bus.cmd_id = 8'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) check("t2_fifth_blocked", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    bus.cmd_valid = 0;
    check("t2_rd_os_4", 64'(dut.rd_os_q), 64'd4);
    bus.axi_rvalid = 1; bus.axi_rid = 8'h10; bus.axi_rdata = 64'h1234; bus.axi_rresp = 0;
    bus.axi_rlast = 1;
    exp_r.push_back('{data: 64'h1234, id: 8'h10, resp: 2'b00, last: 1'b1});
    @(negedge clk) check("t2_ready_during_rlast", 64'(bus.cmd_ready), 64'd0);
    tick();
    bus.axi_rvalid = 0;
    @(negedge clk) check("t2_ready_after_rlast", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.rd_ready = 0;
    bus.axi_rvalid = 1; bus.axi_rid = 8'h11; bus.axi_rdata = 64'h5555; bus.axi_rresp = 2'b10;
    @(negedge clk) check("t2_rready_backpressure", 64'(bus.axi_rready), 64'd0);
    tick();
    bus.rd_ready = 1;
    exp_r.push_back('{data: 64'h5555, id: 8'h11, resp: 2'b10, last: 1'b1});
    tick();
    bus.axi_rvalid = 0;
    send_r(64'h6666, 8'h12, 2'b11);
    send_r(64'h7777, 8'h13, 2'b01);
    @(negedge clk) check("t2_rd_os_0", 64'(dut.rd_os_q), 64'd0);
    tick();

    // AW stalled: W completes first, AW payload held, no new command
    bus.axi_awready = 0;
    exp_aw.push_back('{addr: 32'h3000, len: 4'd1, id: 8'h33});
    send_cmd(1, 32'h3000, 4'd1, 8'h33);
    burst(2, 1, 64'hB000, 8'h0F, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_awvalid_held", 64'(bus.axi_awvalid), 64'd1);
      check("t3_awaddr_stable", 64'(bus.axi_awaddr), 64'h3000);
      check("t3_awlen_stable", 64'(bus.axi_awlen), 64'd1);
      check("t3_cmd_ready_0", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    bus.axi_awready = 1;
    @(negedge clk) check("t3_cmd_ready_on_hs", 64'(bus.cmd_ready), 64'd1);
    tick();
    check("t3_wr_os_1", 64'(dut.wr_os_q), 64'd1);

    // same-cycle AW and B handshakes at wr_os = 2
    exp_aw.push_back('{addr: 32'h4000, len: 4'd0, id: 8'h44});
    send_cmd(1, 32'h4000, 4'd0, 8'h44);
    burst(1, 0, 64'hC000, 8'hFF, 1, 0, 1);
    @(negedge clk) check("t4_wr_os_2", 64'(dut.wr_os_q), 64'd2);
    tick();
    bus.axi_awready = 0;
    exp_aw.push_back('{addr: 32'h5000, len: 4'd0, id: 8'h55});
    send_cmd(1, 32'h5000, 4'd0, 8'h55);
    burst(1, 0, 64'hD000, 8'hFF, 1, 0, 1);
    bus.axi_awready = 1;
    send_b(8'h33, 2'b00);
    @(negedge clk) check("t4_wr_os_same_cycle", 64'(dut.wr_os_q), 64'd2);
    tick();
    send_b(8'h44, 2'b00);
    send_b(8'h55, 2'b10);
    @(negedge clk) check("t4_wr_os_0", 64'(dut.wr_os_q), 64'd0);
    tick();

    // 4 KB boundary: exactly-fitting burst, crossing write, crossing read
    exp_aw.push_back('{addr: 32'h0FE0, len: 4'd3, id: 8'h7E});
    send_cmd(1, 32'h0FE0, 4'd3, 8'h7E);
    burst(4, 3, 64'hE000, 8'hFF, 1, 0, 1);
    send_b(8'h7E, 2'b00);
`ifdef CPU_AXI_MASTER_4K_CHECK_EN
    send_cmd(1, 32'h0FF0, 4'd3, 8'h77);
    burst(4, 3, 64'hF000, 8'hFF, 0, 1, 0);
    @(negedge clk) check("t5_wr_os_no_aw", 64'(dut.wr_os_q), 64'd0);
    tick();
    send_cmd(0, 32'h0FF8, 4'd1, 8'h78);
    @(negedge clk);
    check("t5_rd_err_4k", 64'(bus.err_4k), 64'd1);
    check("t5_rd_no_ar", 64'(bus.axi_arvalid), 64'd0);
    tick();
`else
    exp_aw.push_back('{addr: 32'h0FF0, len: 4'd3, id: 8'h77});
    send_cmd(1, 32'h0FF0, 4'd3, 8'h77);
    burst(4, 3, 64'hF000, 8'hFF, 1, 0, 1);
    send_b(8'h77, 2'b00);
    exp_ar.push_back('{addr: 32'h0FF8, len: 4'd1, id: 8'h78});
    send_cmd(0, 32'h0FF8, 4'd1, 8'h78);
    @(negedge clk);
    check("t5_rd_err_4k", 64'(bus.err_4k), 64'd0);
    check("t5_rd_ar", 64'(bus.axi_arvalid), 64'd1);
    tick();
    send_r(64'h4444, 8'h78, 2'b00);
`endif

    // reset in the middle of a write burst, late responses afterwards
    exp_ar.push_back('{addr: 32'h7000, len: 4'd0, id: 8'h07});
    send_cmd(0, 32'h7000, 4'd0, 8'h07);
    bus.axi_awready = 0;
    exp_aw.push_back('{addr: 32'h6000, len: 4'd3, id: 8'h66});
    send_cmd(1, 32'h6000, 4'd3, 8'h66);
    burst(2, 3, 64'h6600, 8'hFF, 1, 0, 1);
    bus.wd_valid = 1; bus.wd_data = 64'h6602;
    rst = 1;
    tick();
    rst = 0;
    exp_aw.delete();
    bus.cmd_write = 1;
    @(negedge clk);
    check("t6_awvalid", 64'(bus.axi_awvalid), 64'd0);
    check("t6_arvalid", 64'(bus.axi_arvalid), 64'd0);
    check("t6_wvalid", 64'(bus.axi_wvalid), 64'd0);
    check("t6_wd_ready", 64'(bus.wd_ready), 64'd0);
    check("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("t6_wr_os", 64'(dut.wr_os_q), 64'd0);
    check("t6_rd_os", 64'(dut.rd_os_q), 64'd0);
    tick();
    bus.wd_valid = 0;
    bus.axi_awready = 1;
    send_b(8'h66, 2'b11);
    send_r(64'h0707, 8'h07, 2'b00);
    @(negedge clk);
    check("t6_wr_os_saturate", 64'(dut.wr_os_q), 64'd0);
    check("t6_rd_os_saturate", 64'(dut.rd_os_q), 64'd0);
    tick();

    check("end_aw_drained", 64'(exp_aw.size()), 64'd0);
    check("end_ar_drained", 64'(exp_ar.size()), 64'd0);
    check("end_w_drained", 64'(exp_w.size()), 64'd0);
    check("end_b_drained", 64'(exp_b.size()), 64'd0);
    check("end_r_drained", 64'(exp_r.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
